// File: rtl/mips_multi_core.sv
// mips_multi_core: multicycle MIPS-subset core (add/sub/and/or/slt, addi,
// beq, bne, j, lw, sw) with a separate instruction port and a stall-aware
// data port. Unknown opcodes/functs park the core in HALT until reset.
// Optional feature: define MIPS_DBG_PORT_EN to add a third register-file
// read port (dbg_sel/dbg_data).
//
// state     | meaning
// S_FETCH   | IR <- imem_rdata, PC += 4
// S_DECODE  | read A/B, resolve j, trap illegal encodings
// S_EXECUTE | ALU op, branch resolve, address generation
// S_MEM     | data request held until mem_stall is low
// S_WB      | register-file write
// S_HALT    | absorbing, left only through reset
module mips_multi_core #(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  input  logic              mem_stall,
  output logic              instr_done,
`ifdef MIPS_DBG_PORT_EN
  input  logic [4:0]        dbg_sel,
  output logic [31:0]       dbg_data,
`endif
  output logic              halted
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Jump target is built at least 28 bits wide so imm26<<2 always fits,
  // then truncated to the PC width.
  localparam int PW = (ADDR_W > 28) ? ADDR_W : 28;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [31:0]       aluout_q, aluout_d;
  logic [31:0]       mdr_q, mdr_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;
  logic              halted_q, halted_d;
  logic [31:0]       rf_q [32];

  logic [5:0]        opcode, funct;
  logic [4:0]        rs, rt, rd;
  logic [31:0]       imm_sext;
  logic              is_rtype, is_branch, op_legal, br_taken;
  logic [31:0]       alu_res;
  logic [PW-1:0]     j_full;
  logic [ADDR_W-1:0] j_target, br_target;
  logic [4:0]        rf_waddr;
  logic [31:0]       rf_wdata;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};

  // Instruction classification and legality.
  always_comb begin
    is_rtype  = (opcode == OP_RTYPE);
    is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
    if (is_rtype) begin
      op_legal = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    end else begin
      op_legal = opcode inside {OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW};
    end
  end

  // ALU: R-type by funct, everything else is A + sext(imm).
  always_comb begin
    alu_res = a_q + imm_sext;
    if (is_rtype) begin
      case (funct)
        FN_SUB:  alu_res = a_q - b_q;
        FN_AND:  alu_res = a_q & b_q;
        FN_OR:   alu_res = a_q | b_q;
        FN_SLT:  alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
        default: alu_res = a_q + b_q;
      endcase
    end
  end

  // Branch and jump targets; PC already points past the current instruction.
  always_comb begin
    br_taken  = (opcode == OP_BEQ) ? (a_q == b_q) : (a_q != b_q);
    br_target = pc_q + ADDR_W'({imm_sext[29:0], 2'b00});
    j_full        = PW'(pc_q);
    j_full[27:0]  = {ir_q[25:0], 2'b00};
    j_target  = ADDR_W'(j_full);
  end

  // Write-back destination and data.
  always_comb begin
    rf_waddr = is_rtype ? rd : rt;
    rf_wdata = (opcode == OP_LW) ? mdr_q : aluout_q;
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    aluout_d = aluout_q;
    mdr_d    = mdr_q;
    rd_en_d  = rd_en_q;
    wr_en_d  = wr_en_q;
    halted_d = halted_q;
    case (state_q)
      S_FETCH: begin
        ir_d    = imem_rdata;
        pc_d    = pc_q + ADDR_W'(4);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d = rf_q[rs];
        b_d = rf_q[rt];
        if (!op_legal) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else if (opcode == OP_J) begin
          pc_d    = j_target;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        aluout_d = alu_res;
        if (is_branch) begin
          if (br_taken) pc_d = br_target;
          state_d = S_FETCH;
        end else if (opcode == OP_LW) begin
          rd_en_d = 1'b1;
          state_d = S_MEM;
        end else if (opcode == OP_SW) begin
          wr_en_d = 1'b1;
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (!mem_stall) begin
          rd_en_d = 1'b0;
          wr_en_d = 1'b0;
          if (opcode == OP_LW) begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // FSM and datapath registers; enables/halted are registered so they change
  // only on clock edges, and drop immediately on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
      rd_en_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
      mdr_q    <= mdr_d;
      rd_en_q  <= rd_en_d;
      wr_en_q  <= wr_en_d;
      halted_q <= halted_d;
    end
  end

  // Register file write at the edge ending WB; $0 is never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (state_q == S_WB && rf_waddr != 5'd0) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  assign imem_addr = pc_q;
  assign mem_addr  = {aluout_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata = b_q;
  assign mem_rd_en = rd_en_q;
  assign mem_wr_en = wr_en_q;
  assign halted    = halted_q;

  // Completion pulse; a store finishes in the same cycle the cache accepts it,
  // so this has to look at mem_stall combinationally.
  assign instr_done = (state_q == S_WB)
                   || (state_q == S_DECODE  && opcode == OP_J && op_legal)
                   || (state_q == S_EXECUTE && is_branch)
                   || (state_q == S_MEM     && opcode == OP_SW && !mem_stall);

`ifdef MIPS_DBG_PORT_EN
  assign dbg_data = (dbg_sel == 5'd0) ? 32'd0 : rf_q[dbg_sel];
`endif

endmodule

// File: tb/tb_mips_multi_core.sv
// Scoreboard bench for mips_multi_core: stimulus loads a program and pushes
// expected completion cycles and memory transactions; a monitor pops and
// compares whenever instr_done pulses or a data request completes.
module tb_mips_multi_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] imem_addr, mem_addr;
  logic [31:0] imem_rdata, mem_wdata, mem_rdata;
  logic        mem_rd_en, mem_wr_en, mem_stall, instr_done, halted;
`ifdef MIPS_DBG_PORT_EN
  logic [4:0]  dbg_sel = 5'd0;
  logic [31:0] dbg_data;
`endif

  mips_multi_core #(.ADDR_W(12), .RESET_PC(12'h040)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_rd_en  (mem_rd_en),
    .mem_wr_en  (mem_wr_en),
    .mem_stall  (mem_stall),
    .instr_done (instr_done),
`ifdef MIPS_DBG_PORT_EN
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data),
`endif
    .halted     (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] data;
    int          ncyc;
  } txn_t;

  typedef struct {
    int          stall;
    logic [31:0] rdata;
  } rsp_t;

  logic [31:0] rom [1024];
  assign imem_rdata = rom[imem_addr[11:2]];

  int   exp_done[$];
  txn_t exp_txn[$];
  rsp_t rsp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int en_cnt   = 0;

  int done_p1[26] = '{4, 8, 12, 19, 24, 28, 32, 36, 40, 44, 48, 52, 56,
                      60, 63, 66, 69, 73, 77, 79, 86, 90, 94, 98, 102, 104};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
    return {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
  endfunction

  function automatic logic [31:0] enc_j(input int target);
    return {6'h02, target[25:0]};
  endfunction

  task automatic put(input int addr, input logic [31:0] w);
    rom[addr >> 2] = w;
  endtask

  task automatic push_wr(input logic [11:0] addr, input logic [31:0] data, input int stall);
    txn_t t;
    rsp_t r;
    t.wr = 1'b1; t.addr = addr; t.data = data; t.ncyc = stall + 1;
    r.stall = stall; r.rdata = 32'h0;
    exp_txn.push_back(t);
    rsp_q.push_back(r);
  endtask

  task automatic push_rd(input logic [11:0] addr, input logic [31:0] rdata, input int stall);
    txn_t t;
    rsp_t r;
    t.wr = 1'b0; t.addr = addr; t.data = rdata; t.ncyc = stall + 1;
    r.stall = stall; r.rdata = rdata;
    exp_txn.push_back(t);
    rsp_q.push_back(r);
  endtask

  // Data-cache model: drives the stall pattern and read data per request,
  // and holds mem_stall high outside requests to show it is ignored there.
  initial begin : responder
    int stall_left;
    bit in_txn;
    rsp_t r;
    stall_left = 0;
    in_txn     = 1'b0;
    mem_stall  = 1'b1;
    mem_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        in_txn = 1'b0; stall_left = 0; mem_stall = 1'b1;
      end else if (mem_rd_en || mem_wr_en) begin
        if (!in_txn) begin
          in_txn = 1'b1;
          if (rsp_q.size() > 0) begin
            r = rsp_q.pop_front();
            stall_left = r.stall;
            mem_rdata  = r.rdata;
          end else begin
            stall_left = 0;
            mem_rdata  = 32'h0;
          end
        end
        mem_stall = (stall_left > 0);
        if (stall_left > 0) stall_left--;
      end else begin
        in_txn    = 1'b0;
        mem_stall = 1'b1;
      end
    end
  end

  // Monitor: cycle counter plus scoreboard pops on instr_done and on each
  // completed data request.
  initial begin : monitor
    int   e;
    txn_t t;
    forever begin
      @(negedge clk);
      if (!rst) begin
        cyc = 0; en_cnt = 0;
      end else begin
        cyc++;
        if (instr_done) begin
          if (exp_done.size() == 0) begin
            n_checks++;
            $display("FAIL done_unexpected: pulse at cycle %0d, none expected", cyc);
          end else begin
            e = exp_done.pop_front();
            check("done_cycle", cyc, e);
          end
        end
        if (mem_rd_en || mem_wr_en) begin
          en_cnt++;
          if (mem_rd_en && mem_wr_en) begin
            n_checks++;
            $display("FAIL mem_both_en: rd_en=1 wr_en=1 at cycle %0d, required one-hot", cyc);
          end
          if (!mem_stall) begin
            if (exp_txn.size() == 0) begin
              n_checks++;
              $display("FAIL mem_unexpected: request at addr %h cycle %0d, none expected", mem_addr, cyc);
            end else begin
              t = exp_txn.pop_front();
              check("mem_is_write", {31'd0, mem_wr_en}, {31'd0, t.wr});
              check("mem_addr", {20'd0, mem_addr}, {20'd0, t.addr});
              if (t.wr) check("mem_wdata", mem_wdata, t.data);
              check("mem_en_cycles", en_cnt, t.ncyc);
            end
            en_cnt = 0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit seen;
    for (int i = 0; i < 1024; i++) rom[i] = 32'hFC000000;
    put(12'h040, enc_i(8, 0, 1, 5));          // addi $1,$0,5
    put(12'h044, enc_i(8, 0, 2, -3));         // addi $2,$0,-3
    put(12'h048, enc_r(1, 2, 3, 'h20));       // add  $3,$1,$2
    put(12'h04C, enc_i('h2B, 0, 3, 8));       // sw   $3,8($0)
    put(12'h050, enc_i('h23, 0, 4, 8));       // lw   $4,8($0)
    put(12'h054, enc_i('h2B, 0, 4, 12));      // sw   $4,12($0)
    put(12'h058, enc_r(2, 1, 5, 'h2A));       // slt  $5,$2,$1
    put(12'h05C, enc_r(1, 2, 6, 'h22));       // sub  $6,$1,$2
    put(12'h060, enc_r(1, 2, 7, 'h24));       // and  $7,$1,$2
    put(12'h064, enc_r(1, 2, 8, 'h25));       // or   $8,$1,$2
    put(12'h068, enc_i('h2B, 0, 5, 16));      // sw   $5,16($0)
    put(12'h06C, enc_i('h2B, 0, 6, 20));      // sw   $6,20($0)
    put(12'h070, enc_i('h2B, 0, 7, 24));      // sw   $7,24($0)
    put(12'h074, enc_i('h2B, 0, 8, 28));      // sw   $8,28($0)
    put(12'h078, enc_i(4, 1, 1, 1));          // beq  $1,$1,+1 (skips 0x07C)
    put(12'h080, enc_i(5, 1, 1, 4));          // bne  $1,$1,+4 (not taken)
    put(12'h084, enc_i(5, 1, 2, 1));          // bne  $1,$2,+1 (skips 0x088)
    put(12'h088, 32'h0000003F);               // illegal funct, must be skipped
    put(12'h08C, enc_i(8, 0, 0, 7));          // addi $0,$0,7
    put(12'h090, enc_i('h2B, 0, 0, 32));      // sw   $0,32($0)
    put(12'h094, enc_j('h28));                // j    0x0A0
    put(12'h0A0, enc_i('h23, 0, 9, 4));       // lw   $9,4($0)
    put(12'h0A4, enc_i('h2B, 0, 9, 'h23));    // sw   $9,0x23($0) -> addr 0x020
    put(12'h0A8, enc_i(8, 0, 10, -1));        // addi $10,$0,-1
    put(12'h0AC, enc_r(10, 10, 11, 'h20));    // add  $11,$10,$10 (wraps)
    put(12'h0B0, enc_i('h2B, 0, 11, 0));      // sw   $11,0($0)
    put(12'h0B4, enc_j('h3FF));               // j    0xFFC
    // 0xFFC keeps the 0x3F fill word: halts.

    foreach (done_p1[i]) exp_done.push_back(done_p1[i]);
    push_wr(12'h008, 32'h00000002, 3);
    push_rd(12'h008, 32'h00000002, 0);
    push_wr(12'h00C, 32'h00000002, 0);
    push_wr(12'h010, 32'h00000001, 0);
    push_wr(12'h014, 32'h00000008, 0);
    push_wr(12'h018, 32'h00000005, 0);
    push_wr(12'h01C, 32'hFFFFFFFD, 0);
    push_wr(12'h020, 32'h00000000, 0);
    push_rd(12'h004, 32'hDEADBEEF, 2);
    push_wr(12'h020, 32'hDEADBEEF, 0);
    push_wr(12'h000, 32'hFFFFFFFE, 0);

    repeat (3) @(negedge clk);
    check("rst_imem_addr", {20'd0, imem_addr}, 32'h040);
    check("rst_enables", {30'd0, mem_rd_en, mem_wr_en}, 32'h0);
    check("rst_done_halted", {30'd0, instr_done, halted}, 32'h0);
    check("rst_mem_addr", {20'd0, mem_addr}, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);

    @(posedge clk);
    #2 rst = 1'b1;

    for (int i = 0; i < 400 && !halted; i++) begin
      @(negedge clk);
      #1;
    end
    check("halted_set", {31'd0, halted}, 32'h1);
    check("halt_cycle", cyc, 107);
    check("pc_wrapped", {20'd0, imem_addr}, 32'h000);
    repeat (5) @(negedge clk);
    #1;
    check("halt_pc_frozen", {20'd0, imem_addr}, 32'h000);
    check("halt_no_enables", {30'd0, mem_rd_en, mem_wr_en}, 32'h0);
    check("halt_absorbing", {30'd0, halted, instr_done}, 32'h2);
`ifdef MIPS_DBG_PORT_EN
    dbg_sel = 5'd5;  #1 check("dbg_slt", dbg_data, 32'h1);
    dbg_sel = 5'd3;  #1 check("dbg_add", dbg_data, 32'h2);
    dbg_sel = 5'd11; #1 check("dbg_wrap", dbg_data, 32'hFFFFFFFE);
    dbg_sel = 5'd9;  #1 check("dbg_lw", dbg_data, 32'hDEADBEEF);
    dbg_sel = 5'd0;  #1 check("dbg_zero", dbg_data, 32'h0);
`endif

    // Async reset out of HALT, rerun, then reset in the middle of a stalled store.
    rst = 1'b0;
    #1;
    check("rst2_pc", {20'd0, imem_addr}, 32'h040);
    check("rst2_halted", {31'd0, halted}, 32'h0);
    exp_done.push_back(4);
    exp_done.push_back(8);
    exp_done.push_back(12);
    begin
      rsp_t r;
      r.stall = 50; r.rdata = 32'h0;
      rsp_q.push_back(r);
    end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;

    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #3;
      seen = mem_wr_en;
    end
    check("rst2_store_seen", {31'd0, seen}, 32'h1);
    check("rst2_store_addr", {20'd0, mem_addr}, 32'h008);
    check("rst2_store_data", mem_wdata, 32'h2);
    repeat (2) @(posedge clk);
    #3;
    check("stall_held", {30'd0, mem_stall, mem_wr_en}, 32'h3);
    rst = 1'b0;
    #1;
    check("midstall_enables", {30'd0, mem_rd_en, mem_wr_en}, 32'h0);
    check("midstall_pc", {20'd0, imem_addr}, 32'h040);
    check("midstall_addr_data", {20'd0, mem_addr} | mem_wdata, 32'h0);
    check("midstall_done", {31'd0, instr_done}, 32'h0);
    repeat (3) @(negedge clk);

    check("leftover_done", exp_done.size(), 0);
    check("leftover_txn", exp_txn.size(), 0);
    check("leftover_rsp", rsp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_multi_core.md
# mips_multi_core

Parametrised multicycle MIPS-subset core: next generation of the team's multicycle MIPS, with configurable address width and reset vector, a separate instruction port, and a stall-aware data port toward the data cache. Executes one instruction at a time through a FETCH/DECODE/EXECUTE/MEM/WB state machine. Unknown opcodes halt the core. Sits between the instruction ROM and the data cache controller.

## Interface
- ADDR_W, 12, byte-address width of both memory ports and PC (≥ 4).
- RESET_PC, 0, PC value after reset (word-aligned).
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_addr  out  ADDR_W  instruction byte address (= PC).
- imem_rdata  in  32  instruction word, combinationally valid for current imem_addr.
- mem_addr  out  ADDR_W  data byte address, bits [1:0] forced 0.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  load data, valid in the cycle mem_stall is low.
- mem_rd_en  out  1  load request, held through stall.
- mem_wr_en  out  1  store request, held through stall.
- mem_stall  in  1  cache busy; request not complete while high.
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction.
- halted  out  1  high in HALT.

## Operation
- Register file: 32×32, $0 reads 0 and ignores writes. Two async read ports and one write port, written at the rising edge ending WB.
- Supported: R-type add, sub, and, or, slt (funct 0x20, 0x22, 0x24, 0x25, 0x2A); addi (0x08); beq (0x04); bne (0x05); j (0x02); lw (0x23); sw (0x2B). Any other opcode, or an R-type with any other funct, goes to HALT.
- Immediates are sign-extended to 32 bits. All arithmetic is 32-bit wraparound with no overflow trap. slt is a signed compare producing 1 or 0.
- FETCH:
  - IR ← imem_rdata; PC ← PC+4, truncated to ADDR_W.
  - → DECODE.
- DECODE:
  - A ← R[rs]; B ← R[rt].
  - j: PC ← {PC[ADDR_W-1:28] if ADDR_W>28, imm26<<2}, truncated to ADDR_W; → FETCH.
  - Illegal opcode or funct: → HALT.
  - Otherwise: → EXECUTE.
- EXECUTE:
  - ALU result → ALUOut.
  - beq/bne: if taken, PC ← PC + (sext(imm)<<2), where PC is already +4. → FETCH.
  - lw/sw: ALUOut = A + sext(imm). → MEM.
  - R-type/addi: → WB.
- MEM:
  - mem_addr = ALUOut[ADDR_W-1:2],2'b0. lw drives mem_rd_en=1; sw drives mem_wr_en=1 with mem_wdata=B.
  - Stay in MEM while mem_stall=1.
  - First cycle with mem_stall=0: lw latches MDR ← mem_rdata and goes → WB; sw goes → FETCH.
- WB:
  - Destination and data: R-type writes rd ← ALUOut; addi writes rt ← ALUOut; lw writes rt ← MDR.
  - → FETCH.
- HALT: absorbing; only rst leaves it.
- Memory enables are asserted only in MEM and are never both high. mem_addr and mem_wdata are held stable for the whole request.

## Timing
- Reset state:
  - State = FETCH; PC = RESET_PC.
  - IR, A, B, ALUOut, MDR and all registers = 0.
  - mem_rd_en = mem_wr_en = instr_done = halted = 0; mem_addr = mem_wdata = 0.
- Latency in cycles (s = stall cycles):
  - j: 2.
  - beq/bne: 3.
  - R-type/addi: 4.
  - sw: 4+s.
  - lw: 5+s.
- instr_done is high in the final state cycle: DECODE for j, EXECUTE for branches, MEM completion for sw, WB otherwise.
- mem_stall is sampled every MEM cycle. A stall of 0 completes the request in a single MEM cycle.
- Reset asserted mid-instruction, including MEM under stall, immediately clears the core. Enables drop asynchronously and no register write occurs.
- mem_stall outside MEM is ignored.

## Configuration
- MIPS_DBG_PORT_EN defined:
  - Adds ports dbg_sel (in, 5) and dbg_data (out, 32).
  - dbg_data is a combinational third read port of the register file; dbg_sel=0 returns 0.
  - Core timing is unchanged.
- Undefined: the ports are absent and the register file has two read ports.

## Test plan
- Reset with RESET_PC=0x040, run addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2 -> $3=2; instr_done pulses at cycles 4, 8, 12.
- sw $3,8($0) with mem_stall high for 3 cycles, then lw $4,8($0) with rdata=0x2 and no stall -> mem_wr_en high for 4 cycles at mem_addr=0x008 with wdata=2; $4=2 five cycles after lw fetch.
- beq $1,$1,-1 at PC 0x010 -> PC returns to 0x010 in 3 cycles; bne $1,$1,+4 -> not taken, next fetch at PC+4.
- j 0x3FF with ADDR_W=12 -> next imem_addr=0xFFC; addi $0,$0,7 -> $0 stays 0.
- Opcode 0x3F -> halted=1 after DECODE, no memory enables, PC frozen; async rst low mid-stall clears enables in the same cycle.
- With MIPS_DBG_PORT_EN: after slt $5,$2,$1 (-3<5), dbg_sel=5 -> dbg_data=1.
